// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared encodings for the fetch controller: ProgramCounter operation codes and FSM states.
package pc_fetch_ctrl_pkg;

  localparam logic [2:0] PC_INC  = 3'd0;
  localparam logic [2:0] PC_HOLD = 3'd1;
  localparam logic [2:0] PC_LOAD = 3'd2;
  localparam logic [2:0] PC_REL  = 3'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetchStateT;

endpackage

// File: rtl/pc_fetch_ctrl_fetch_buffer.sv
// Circular FIFO of {instruction, pc} pairs between instruction memory and decode.
module fetch_buffer #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [XLEN-1:0] pushInstr,
  input  logic [XLEN-1:0] pushPc,
  input  logic            pop,
  input  logic            flush,
  output logic            headValid,
  output logic [XLEN-1:0] headInstr,
  output logic [XLEN-1:0] headPc,
  output logic [CW-1:0]   count
);

  logic [XLEN-1:0] instrMem [DEPTH];
  logic [XLEN-1:0] pcMem    [DEPTH];
  logic [AW-1:0]   rdPtr;
  logic [AW-1:0]   wrPtr;
  logic            doPush;
  logic            doPop;

  assign doPop  = pop && (count != '0);
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign doPush = push && ((count != CW'(DEPTH)) || doPop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush && !rst && !flush) begin
      instrMem[wrPtr] <= pushInstr;
      pcMem[wrPtr]    <= pushPc;
    end
  end

  assign headValid = (count != '0);
  assign headInstr = headValid ? instrMem[rdPtr] : '0;
  assign headPc    = headValid ? pcMem[rdPtr]    : '0;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch controller: steps the ProgramCounter, issues instruction reads one at a time,
// buffers returned words with their PC and presents them to decode; redirects flush.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pcReadData,
  output logic            pcWriteEnable,
  output logic [XLEN-1:0] pcWriteData,
  output logic [2:0]      pcOp,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect_valid,
  input  logic            redirect_rel,
  input  logic [XLEN-1:0] redirect_target,
  output fetchStateT      dbgState
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Handshakes: a transfer happens on a cycle where valid and ready are both high at the
  // rising edge; valid never depends on ready, and payload is held only while valid is high.

  fetchStateT      state;
  fetchStateT      stateNext;
  logic            dropQ;
  logic            dropNext;
  logic [XLEN-1:0] pcQ;
  logic [CW-1:0]   count;
  logic            reqAccept;
  logic            stillOut;
  logic            push;
  logic            pop;
  logic            flush;
  logic [2:0]      opSel;

  // Only ask memory when the answer is guaranteed a slot in the buffer.
  assign imem_req_valid = (state == REQ) && (count < CW'(DEPTH));
  assign imem_addr      = imem_req_valid ? pcReadData : '0;
  assign reqAccept      = imem_req_valid && imem_req_ready;
  assign stillOut       = (state == WAIT) && !imem_rsp_valid;

  always_comb begin
    stateNext   = state;
    dropNext    = dropQ;
    opSel       = PC_HOLD;
    pcWriteData = '0;
    push        = 1'b0;
    pop         = instr_valid && instr_ready;
    flush       = 1'b0;

    case (state)
      IDLE: stateNext = REQ;
      REQ: begin
        if (reqAccept) begin
          stateNext = WAIT;
          opSel     = PC_INC;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          push      = !dropQ;
          dropNext  = 1'b0;
          stateNext = REQ;
        end
      end
      default: stateNext = IDLE;
    endcase

    // A taken branch wins over everything; the one response still owed by memory
    // (already in flight, or accepted right now) must be thrown away when it lands.
    if (redirect_valid) begin
      opSel       = redirect_rel ? PC_REL : PC_LOAD;
      pcWriteData = redirect_target;
      flush       = 1'b1;
      push        = 1'b0;
      pop         = 1'b0;
      dropNext    = stillOut || reqAccept;
      stateNext   = (stillOut || reqAccept) ? WAIT : REQ;
    end
  end

  assign pcWriteEnable = (opSel != PC_HOLD);
  assign pcOp          = pcWriteEnable ? opSel : 3'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dropQ <= 1'b0;
      pcQ   <= '0;
    end else begin
      state <= stateNext;
      dropQ <= dropNext;
      if (reqAccept) pcQ <= pcReadData;
    end
  end

  fetch_buffer #(
    .DEPTH(DEPTH),
    .XLEN (XLEN)
  ) u_buffer (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pushInstr(imem_rsp_data),
    .pushPc   (pcQ),
    .pop      (pop),
    .flush    (flush),
    .headValid(instr_valid),
    .headInstr(instr_data),
    .headPc   (instr_pc),
    .count    (count)
  );

  assign dbgState = state;

endmodule
